// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scan controller for the serial digit display path.
// Stores one frame word per digit and generates the divided serial clock.
// Sequences a load pulse, FRAME_BITS shift clocks and a gap for each digit,
// then latches the digit strobe. Digits are scanned round-robin while enabled.
// Optional feature macro: DISPLAY_SCAN_DBUF_EN (shadow/live double buffer).
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCLK_DIV   = 256,
  parameter int FRAME_BITS = 32
) (
  input  logic                          int_osc,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [FRAME_BITS-1:0]         wr_data,
  output logic                          sclk,
  output logic                          load_data,
  output logic [FRAME_BITS-1:0]         data_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DW-1:0]       div;
  logic [BW-1:0]       bitcnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_inc;
  logic                tick;
  logic                fall_tick;
  logic                rise_tick;
  logic                last_idx;
  logic                gap_end;
  logic                wrap;
  logic                addr_ok;
  logic [FRAME_BITS-1:0] cur_word;
  logic [FRAME_BITS-1:0] next_word;

  logic [FRAME_BITS-1:0] live [NUM_DIGITS];

  // Divider terminal count and sclk edge qualifiers
  always_comb begin
    tick      = 1'b0;
    if (state != IDLE && div == DW'(SCLK_DIV - 1)) begin
      tick = 1'b1;
    end
    fall_tick = tick & sclk;
    rise_tick = tick & ~sclk;
    last_idx  = (idx == IW'(NUM_DIGITS - 1));
    idx_inc   = last_idx ? '0 : idx + 1'b1;
    gap_end   = (state == GAP) & fall_tick;
    wrap      = gap_end & last_idx;
    addr_ok   = ({1'b0, wr_addr} <= (IW + 1)'(NUM_DIGITS - 1));
  end

  // State register
  always_ff @(posedge int_osc) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a disable request is only honoured at the end of GAP
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = LOAD;
      LOAD:    if (fall_tick) state_nxt = SHIFT;
      SHIFT:   if (fall_tick && bitcnt == BW'(FRAME_BITS)) state_nxt = GAP;
      GAP:     if (fall_tick) state_nxt = en ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign load_data = (state == LOAD);

  // Serial clock divider; parked at zero with sclk low while idle
  always_ff @(posedge int_osc) begin
    if (rst) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (state == IDLE) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      div  <= '0;
      sclk <= ~sclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

  // Count shift clocks delivered during SHIFT
  always_ff @(posedge int_osc) begin
    if (rst) begin
      bitcnt <= '0;
    end else if (state == LOAD) begin
      bitcnt <= '0;
    end else if (state == SHIFT && rise_tick) begin
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // Digit index, frame word presented to the shifter, strobe and frame pulse
  always_ff @(posedge int_osc) begin
    if (rst) begin
      idx        <= '0;
      data_out   <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (state == IDLE && en) begin
        data_out <= cur_word;
      end
      if (state == SHIFT && state_nxt == GAP) begin
        digit_sel <= NUM_DIGITS'(1) << idx;
      end
      if (gap_end) begin
        idx <= idx_inc;
        if (en) begin
          data_out <= next_word;
        end
      end
    end
  end

  assign cur_word = live[idx];

`ifdef DISPLAY_SCAN_DBUF_EN
  logic [FRAME_BITS-1:0] shadow [NUM_DIGITS];

  // Host writes land in the shadow copy
  always_ff @(posedge int_osc) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_en && addr_ok) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Live copy refreshes only between frames so a scanned frame is coherent
  always_ff @(posedge int_osc) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        live[i] <= '0;
      end
    end else if (wrap || (state == IDLE && !en)) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        live[i] <= shadow[i];
      end
    end
  end

  // On the frame wrap the live copy is refreshed in the same edge, so the
  // first digit of the new frame is taken straight from the shadow copy.
  assign next_word = wrap ? shadow[idx_inc] : live[idx_inc];
`else
  // Host writes go straight into the single buffer
  always_ff @(posedge int_osc) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        live[i] <= '0;
      end
    end else if (wr_en && addr_ok) begin
      live[wr_addr] <= wr_data;
    end
  end

  assign next_word = live[idx_inc];
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: phase-counter reference model compared every
// cycle, a serial-shifter capture model, and directed literal expectations.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int FB  = 32;
  localparam int PER = 2 * DIV * (FB + 2);

  logic int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  logic        rst, en, wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sclk, load_data, busy, frame_done;
  logic [31:0] data_out;
  logic [3:0]  digit_sel;

  logic        en3, wr_en3;
  logic [1:0]  wr_addr3;
  logic [31:0] wr_data3;
  logic        sclk3, load3, busy3, fd3;
  logic [31:0] data3;
  logic [2:0]  dsel3;

  display_scan_ctrl #(.NUM_DIGITS(ND), .SCLK_DIV(DIV), .FRAME_BITS(FB)) dut (
    .int_osc(int_osc), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sclk(sclk), .load_data(load_data), .data_out(data_out),
    .digit_sel(digit_sel), .busy(busy), .frame_done(frame_done)
  );

  display_scan_ctrl #(.NUM_DIGITS(3), .SCLK_DIV(DIV), .FRAME_BITS(FB)) dut3 (
    .int_osc(int_osc), .rst(rst), .en(en3), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .sclk(sclk3), .load_data(load3), .data_out(data3),
    .digit_sel(dsel3), .busy(busy3), .frame_done(fd3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one phase counter per digit, p = cycles since LOAD entry
  bit          m_busy;
  int          m_p;
  int          m_idx;
  logic [31:0] m_dout;
  logic [3:0]  m_dsel;
  bit          m_fd;
  logic [31:0] m_live   [ND];
  logic [31:0] m_shadow [ND];
  logic [31:0] old_sh   [ND];

  always @(posedge int_osc) begin
    if (rst) begin
      m_busy = 0; m_p = 0; m_idx = 0; m_dout = '0; m_dsel = '0; m_fd = 0;
      for (int i = 0; i < ND; i++) begin m_live[i] = '0; m_shadow[i] = '0; end
    end else begin
      old_sh = m_shadow;
      m_fd   = 0;
`ifdef DISPLAY_SCAN_DBUF_EN
      if (!m_busy && !en) m_live = old_sh;
`endif
      if (!m_busy) begin
        if (en) begin m_busy = 1; m_p = 0; m_dout = m_live[m_idx]; end
      end else if (m_p == PER - 1) begin
        m_idx = (m_idx + 1) % ND;
        if (m_idx == 0) begin
          m_fd = 1;
`ifdef DISPLAY_SCAN_DBUF_EN
          m_live = old_sh;
`endif
        end
        if (en) begin m_p = 0; m_dout = m_live[m_idx]; end
        else m_busy = 0;
      end else begin
        m_p++;
        if (m_p == 2 * DIV * (FB + 1)) m_dsel = 4'b0001 << m_idx;
      end
      if (wr_en && wr_addr < ND) begin
`ifdef DISPLAY_SCAN_DBUF_EN
        m_shadow[wr_addr] = wr_data;
`else
        m_live[wr_addr] = wr_data;
`endif
      end
    end
  end

  bit chk_on = 0;
  logic m_sclk, m_load;
  assign m_sclk = m_busy && ((m_p / DIV) % 2 == 1);
  assign m_load = m_busy && (m_p < 2 * DIV);

  // Per-cycle comparison of every output against the model
  always @(negedge int_osc) begin
    if (chk_on) begin
      check("cycle_outputs",
            {sclk, load_data, busy, frame_done, digit_sel, data_out},
            {m_sclk, m_load, m_busy, m_fd, m_dsel, m_dout});
    end
  end

  // Serial shifter model and pulse-shape monitor
  logic [31:0] capq [$];
  logic [31:0] cap3 [$];
  logic [3:0]  dlog [$];
  logic prev_sclk = 0, prev_load = 0, prev_sclk3 = 0;
  logic [3:0] prev_dsel = '0;
  int lcyc = 0, lrise = 0, rc = 0;
  bit armed = 0;

  always @(negedge int_osc) begin
    logic s_rise;
    s_rise = sclk && !prev_sclk;
    if (rst) begin
      armed = 0; lcyc = 0; lrise = 0;
    end else if (chk_on) begin
      if (load_data) begin
        if (!prev_load) begin
          check("load_rise_sclk_low", sclk, 0);
          lcyc = 0; lrise = 0;
        end
        lcyc++;
        if (s_rise) lrise++;
      end else if (prev_load) begin
        check("load_width", lcyc, 2 * DIV);
        check("load_samples", lrise, 1);
        armed = 1; rc = 0;
      end
      if (armed && s_rise) rc++;
      if (armed && digit_sel != prev_dsel) begin
        check("shift_rises", rc, FB);
        armed = 0;
      end
      if (digit_sel != prev_dsel && digit_sel != 0) dlog.push_back(digit_sel);
      if (s_rise && load_data) capq.push_back(data_out);
      if (sclk3 && !prev_sclk3 && load3) cap3.push_back(data3);
    end
    prev_sclk  = sclk;
    prev_load  = load_data;
    prev_dsel  = digit_sel;
    prev_sclk3 = sclk3;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge int_osc);
    wr_en = 0;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [31:0] d);
    wr_en3 = 1; wr_addr3 = a; wr_data3 = d;
    @(negedge int_osc);
    wr_en3 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    logic quiet;
    rst = 1; en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    en3 = 0; wr_en3 = 0; wr_addr3 = '0; wr_data3 = '0;
    @(negedge int_osc); chk_on = 1;
    @(negedge int_osc); rst = 0;
    check("reset_state", {sclk, load_data, busy, frame_done, digit_sel, data_out}, '0);

    quiet = 0;
    repeat (100) begin
      @(negedge int_osc);
      quiet = quiet | sclk | load_data | busy | (|digit_sel);
    end
    check("idle_quiet", quiet, 0);

    // Full scan
    wr(2'd0, 32'hF0F00F0F);
    wr(2'd1, 32'h12345678);
    wr(2'd2, 32'hDEADBEEF);
    wr(2'd3, 32'h00000000);
    @(negedge int_osc);
    en = 1;
    @(negedge int_osc);
    check("first_load", load_data, 1);
    k = 0;
    while (!frame_done && k < 2000) begin @(negedge int_osc); k++; end
    check("frame_period", k, 4 * PER);
    check("frame1_count", capq.size(), 4);
    check("frame1_w0", capq[0], 32'hF0F00F0F);
    check("frame1_w1", capq[1], 32'h12345678);
    check("frame1_w2", capq[2], 32'hDEADBEEF);
    check("frame1_w3", capq[3], 32'h00000000);
    check("dsel_0", dlog[0], 4'b0001);
    check("dsel_1", dlog[1], 4'b0010);
    check("dsel_2", dlog[2], 4'b0100);
    check("dsel_3", dlog[3], 4'b1000);

    // Write to digit 1 in the very cycle its word is sampled
    repeat (PER - 1) @(negedge int_osc);
    wr(2'd1, 32'hAAAA5555);
    k = 0;
    while (!frame_done && k < 2000) begin @(negedge int_osc); k++; end
    check("frame2_wait", k < 2000, 1);
    check("frame2_w0", capq[4], 32'hF0F00F0F);
    check("collision_old", capq[5], 32'h12345678);
    check("frame2_w2", capq[6], 32'hDEADBEEF);

    // Drop enable during SHIFT of digit 2 in frame 3
    k = 0;
    while (capq.size() < 11 && k < 2000) begin @(negedge int_osc); k++; end
    check("frame3_wait", k < 2000, 1);
    check("collision_new", capq[9], 32'hAAAA5555);
    repeat (50) @(negedge int_osc);
    en = 0;
    k = 0;
    while (busy && k < 2000) begin @(negedge int_osc); k++; end
    check("disable_wait", k < 2000, 1);
    check("disable_sclk", sclk, 0);
    check("disable_dsel", digit_sel, 4'b0100);
    check("disable_count", capq.size(), 11);

    // Digit 3 written while idle; scan resumes at the advanced index
    wr(2'd3, 32'h3333CCCC);
    @(negedge int_osc);
    en = 1;
    k = 0;
    while (capq.size() < 14 && k < 2000) begin @(negedge int_osc); k++; end
    check("resume_wait", k < 2000, 1);
    check("resume_w3", capq[11], 32'h3333CCCC);
    check("resume_w0", capq[12], 32'hF0F00F0F);

    // Reset in SHIFT of digit 1, then restart from digit 0
    repeat (40) @(negedge int_osc);
    rst = 1; en = 0;
    @(negedge int_osc);
    check("midreset_state", {sclk, load_data, busy, frame_done, digit_sel, data_out}, '0);
    rst = 0;
    wr(2'd0, 32'h0BADF00D);
    @(negedge int_osc);
    en = 1;
    k = 0;
    while (capq.size() < 15 && k < 2000) begin @(negedge int_osc); k++; end
    check("restart_wait", k < 2000, 1);
    check("restart_w0", capq[14], 32'h0BADF00D);
    k = 0;
    while (digit_sel == 4'b0000 && k < 2000) begin @(negedge int_osc); k++; end
    check("restart_dsel", digit_sel, 4'b0001);
    en = 0;
    k = 0;
    while (busy && k < 2000) begin @(negedge int_osc); k++; end
    check("restart_idle", k < 2000, 1);

    // Three-digit build: address 3 is outside the scan and must be dropped
    wr3(2'd0, 32'h11111111);
    wr3(2'd1, 32'h22222222);
    wr3(2'd2, 32'h33333333);
    wr3(2'd3, 32'hFFFFFFFF);
    @(negedge int_osc);
    en3 = 1;
    k = 0;
    while (cap3.size() < 4 && k < 2000) begin @(negedge int_osc); k++; end
    en3 = 0;
    check("nd3_wait", k < 2000, 1);
    check("nd3_w0", cap3[0], 32'h11111111);
    check("nd3_w1", cap3[1], 32'h22222222);
    check("nd3_w2", cap3[2], 32'h33333333);
    check("nd3_wrap", cap3[3], 32'h11111111);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
